// File: rtl/itrx_aib_phy_out_bsr.sv
// AIB JTAG output boundary-scan register: WIDTH cells with shift, update, position counter and wrap pulse.
// Optional AC-toggle mode is enabled by defining ITRX_AIB_PHY_BSR_AC_EN.
module itrx_aib_phy_out_bsr #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             jtag_clkdr,
  input  logic             jtag_rst,
  input  logic             jtag_scan_en,
  input  logic             jtag_intest,
  input  logic             jtag_update,
  input  logic             jtag_mode,
`ifdef ITRX_AIB_PHY_BSR_AC_EN
  input  logic             jtag_ac_mode,
`endif
  input  logic [WIDTH-1:0] d_i,
  input  logic             si,
  output logic [WIDTH-1:0] d_o,
  output logic             so,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             shift_wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh_reg_q, sh_reg_d;
  logic [WIDTH-1:0] upd_reg_q, upd_reg_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic             shift_wrap_q, shift_wrap_d;

  always_comb begin
    sh_reg_d     = sh_reg_q;
    shift_cnt_d  = shift_cnt_q;
    shift_wrap_d = 1'b0;
    if (jtag_scan_en) begin
      sh_reg_d = {sh_reg_q[WIDTH-2:0], si};
      // Compare against WIDTH-1 so non-power-of-2 widths never count past the last cell.
      if (shift_cnt_q == CNT_MAX) begin
        shift_cnt_d  = '0;
        shift_wrap_d = 1'b1;
      end else begin
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
      end
    end else if (jtag_intest) begin
      sh_reg_d    = d_i;
      shift_cnt_d = '0;
    end
  end

  always_comb begin
    upd_reg_d = upd_reg_q;
    if (jtag_update) upd_reg_d = sh_reg_q;
  end

  always_ff @(posedge jtag_clkdr) begin
    if (jtag_rst) begin
      sh_reg_q     <= '0;
      upd_reg_q    <= '0;
      shift_cnt_q  <= '0;
      shift_wrap_q <= 1'b0;
    end else begin
      sh_reg_q     <= sh_reg_d;
      upd_reg_q    <= upd_reg_d;
      shift_cnt_q  <= shift_cnt_d;
      shift_wrap_q <= shift_wrap_d;
    end
  end

`ifdef ITRX_AIB_PHY_BSR_AC_EN
  logic ac_tgl_q, ac_tgl_d;

  always_comb begin
    ac_tgl_d = 1'b0;
    if (jtag_mode && jtag_ac_mode) ac_tgl_d = ~ac_tgl_q;
  end

  always_ff @(posedge jtag_clkdr) begin
    if (jtag_rst) ac_tgl_q <= 1'b0;
    else          ac_tgl_q <= ac_tgl_d;
  end

  assign d_o = jtag_mode ? (upd_reg_q ^ {WIDTH{ac_tgl_q & jtag_ac_mode}}) : d_i;
`else
  assign d_o = jtag_mode ? upd_reg_q : d_i;
`endif

  assign so         = sh_reg_q[WIDTH-1];
  assign shift_cnt  = shift_cnt_q;
  assign shift_wrap = shift_wrap_q;

endmodule
